o_serializer: RTL and testbench

Parallel-to-serial transmit block for the output IO path. It accepts WIDTH-bit words over a valid/ready handshake and emits them LSB-first, one bit per clock (SDR) or two bits per clock (DDR). Q[1:0] drives the D[1:0] pair of the output DDR cell, and OE drives the enable of the tristate output buffer. It is the transmit counterpart of the input deserializer path.

---
 rtl/o_serializer.sv | 118 +++++++++++
 tb/tb_o_serializer.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/o_serializer.sv
// Parallel-to-serial transmitter for the output IO path: WIDTH-bit words in over
// valid/ready, streamed LSB-first as SDR or DDR beats driving an output DDR cell.
module o_serializer #(
  parameter int WIDTH     = 8,
  parameter     DATA_RATE = "DDR"
) (
  input  logic             C,
  input  logic             R,
  input  logic [WIDTH-1:0] D,
  input  logic             D_VALID,
  output logic             D_READY,
  input  logic             EN,
  output logic [1:0]       Q,
  output logic             OE,
  output logic             WORD_START,
  output logic             UNDERFLOW
);

  localparam bit IS_DDR = (DATA_RATE == "DDR");
  localparam int BEATS  = IS_DDR ? WIDTH / 2 : WIDTH;
  localparam int STEP   = IS_DDR ? 2 : 1;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LAST   = BEATS - 1;

  generate
    if (DATA_RATE != "SDR" && DATA_RATE != "DDR") begin : g_bad_rate
      $error("o_serializer: DATA_RATE must be SDR or DDR");
    end
    if (IS_DDR && (WIDTH < 4 || WIDTH > 16 || (WIDTH % 2) != 0)) begin : g_bad_ddr_width
      $error("o_serializer: DDR WIDTH must be even and within 4..16");
    end
    if (DATA_RATE == "SDR" && (WIDTH < 2 || WIDTH > 16)) begin : g_bad_sdr_width
      $error("o_serializer: SDR WIDTH must be within 2..16");
    end
  endgenerate

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] hold_reg;
  logic             hold_full_reg;
  logic [WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [1:0]       q_reg;
  logic             oe_reg;
  logic             word_start_reg;
  logic             underflow_reg;
  logic             uf_arm_reg;
  logic [1:0]       beat_q;

  // SDR repeats the current bit on both DDR-cell inputs so the pin holds for a full cycle.
  assign beat_q = IS_DDR ? {shift_reg[1], shift_reg[0]} : {shift_reg[0], shift_reg[0]};

  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      state_reg      <= ST_IDLE;
      hold_reg       <= '0;
      hold_full_reg  <= 1'b0;
      shift_reg      <= '0;
      cnt_reg        <= '0;
      q_reg          <= 2'b00;
      oe_reg         <= 1'b0;
      word_start_reg <= 1'b0;
      underflow_reg  <= 1'b0;
      uf_arm_reg     <= 1'b0;
    end else begin
      // Accept and drain are mutually exclusive: accept needs an empty holding buffer.
      if (D_VALID && !hold_full_reg) begin
        hold_reg      <= D;
        hold_full_reg <= 1'b1;
      end
      underflow_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          q_reg          <= 2'b00;
          oe_reg         <= 1'b0;
          word_start_reg <= 1'b0;
          underflow_reg  <= uf_arm_reg;
          uf_arm_reg     <= 1'b0;
          if (hold_full_reg && EN) begin
            shift_reg     <= hold_reg;
            hold_full_reg <= 1'b0;
            cnt_reg       <= '0;
            state_reg     <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          q_reg          <= beat_q;
          oe_reg         <= 1'b1;
          word_start_reg <= (cnt_reg == '0);
          if (cnt_reg == CNT_W'(LAST)) begin
            cnt_reg <= '0;
            if (hold_full_reg && EN) begin
              shift_reg     <= hold_reg;
              hold_full_reg <= 1'b0;
            end else begin
              // Underflow is reported on the first idle beat, only if the link was still enabled.
              shift_reg  <= '0;
              uf_arm_reg <= EN;
              state_reg  <= ST_IDLE;
            end
          end else begin
            cnt_reg   <= cnt_reg + CNT_W'(1);
            shift_reg <= shift_reg >> STEP;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign D_READY    = R && !hold_full_reg;
  assign Q          = q_reg;
  assign OE         = oe_reg;
  assign WORD_START = word_start_reg;
  assign UNDERFLOW  = underflow_reg;

endmodule

// File: tb/tb_o_serializer.sv
// Scoreboard bench for o_serializer: three instances (DDR/8, SDR/8, DDR/4) with
// expected beats queued at acceptance and compared as OE beats emerge.
module tb_o_serializer;

  typedef struct packed {
    logic [1:0] q;
    logic       ws;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] a_d = '0;
  logic a_v = 0, a_en = 0, a_rdy, a_oe, a_ws, a_uf;
  logic [1:0] a_q;
  logic [7:0] b_d = '0;
  logic b_v = 0, b_en = 0, b_rdy, b_oe, b_ws, b_uf;
  logic [1:0] b_q;
  logic [3:0] c_d = '0;
  logic c_v = 0, c_en = 0, c_rdy, c_oe, c_ws, c_uf;
  logic [1:0] c_q;

  o_serializer #(.WIDTH(8), .DATA_RATE("DDR")) u_a (
    .C(clk), .R(rst_n), .D(a_d), .D_VALID(a_v), .D_READY(a_rdy), .EN(a_en),
    .Q(a_q), .OE(a_oe), .WORD_START(a_ws), .UNDERFLOW(a_uf));
  o_serializer #(.WIDTH(8), .DATA_RATE("SDR")) u_b (
    .C(clk), .R(rst_n), .D(b_d), .D_VALID(b_v), .D_READY(b_rdy), .EN(b_en),
    .Q(b_q), .OE(b_oe), .WORD_START(b_ws), .UNDERFLOW(b_uf));
  o_serializer #(.WIDTH(4), .DATA_RATE("DDR")) u_c (
    .C(clk), .R(rst_n), .D(c_d), .D_VALID(c_v), .D_READY(c_rdy), .EN(c_en),
    .Q(c_q), .OE(c_oe), .WORD_START(c_ws), .UNDERFLOW(c_uf));

  int n_tests = 0;
  int n_fail  = 0;
  beat_t exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void push_word(input logic [15:0] w, input int beats, input bit ddr);
    beat_t e;
    for (int k = 0; k < beats; k++) begin
      e.q  = ddr ? {w[2*k+1], w[2*k]} : {w[k], w[k]};
      e.ws = (k == 0);
      exp_q.push_back(e);
    end
  endfunction

  task automatic test_reset();
    #23;
    n_tests++;
    if (a_q !== 2'b00 || a_oe !== 1'b0 || a_ws !== 1'b0 || a_uf !== 1'b0 || a_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: q=%b oe=%b ws=%b uf=%b rdy=%b, expected all 0", a_q, a_oe, a_ws, a_uf, a_rdy);
    end
    tick();
    rst_n = 1'b1;
    tick();
    n_tests++;
    if (a_rdy !== 1'b1 || b_rdy !== 1'b1 || c_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: rdy a=%b b=%b c=%b, expected 1 1 1", a_rdy, b_rdy, c_rdy);
    end
  endtask

  task automatic test_ddr_single();
    beat_t e;
    int lat = -1;
    exp_q.delete();
    a_en = 1; a_d = 8'hA5; a_v = 1;
    n_tests++;
    if (a_rdy !== 1'b1) begin n_fail++; $display("FAIL ddr_single_ready: rdy=%b, expected 1", a_rdy); end
    push_word(16'h00A5, 4, 1'b1);
    for (int cyc = 1; cyc <= 30 && exp_q.size() > 0; cyc++) begin
      tick();
      a_v = 0;
      if (a_oe) begin
        if (lat < 0) lat = cyc;
        e = exp_q.pop_front();
        n_tests++;
        if (a_q !== e.q || a_ws !== e.ws || a_uf !== 1'b0) begin
          n_fail++;
          $display("FAIL ddr_single_beat: q=%b ws=%b uf=%b, expected q=%b ws=%b uf=0", a_q, a_ws, a_uf, e.q, e.ws);
        end
      end else if (lat >= 0) begin
        n_tests++; n_fail++;
        $display("FAIL ddr_single_gap: oe=0 mid-word, expected 1");
      end
    end
    n_tests++;
    if (exp_q.size() != 0 || lat != 3) begin
      n_fail++;
      $display("FAIL ddr_single_latency: first beat cycle=%0d left=%0d, expected cycle 3 left 0", lat, exp_q.size());
    end
    tick();
    n_tests++;
    if (a_uf !== 1'b1 || a_oe !== 1'b0 || a_q !== 2'b00) begin
      n_fail++;
      $display("FAIL ddr_single_underflow: uf=%b oe=%b q=%b, expected uf=1 oe=0 q=00", a_uf, a_oe, a_q);
    end
    tick();
    n_tests++;
    if (a_uf !== 1'b0) begin n_fail++; $display("FAIL ddr_single_uf_pulse: uf=%b, expected 0", a_uf); end
  endtask

  task automatic test_sdr_single();
    beat_t e;
    int lat = -1;
    exp_q.delete();
    b_en = 1; b_d = 8'h3C; b_v = 1;
    push_word(16'h003C, 8, 1'b0);
    for (int cyc = 1; cyc <= 40 && exp_q.size() > 0; cyc++) begin
      tick();
      b_v = 0;
      if (b_oe) begin
        if (lat < 0) lat = cyc;
        e = exp_q.pop_front();
        n_tests++;
        if (b_q !== e.q || b_ws !== e.ws || b_uf !== 1'b0) begin
          n_fail++;
          $display("FAIL sdr_single_beat: q=%b ws=%b uf=%b, expected q=%b ws=%b uf=0", b_q, b_ws, b_uf, e.q, e.ws);
        end
      end else if (lat >= 0) begin
        n_tests++; n_fail++;
        $display("FAIL sdr_single_gap: oe=0 mid-word, expected 1");
      end
    end
    n_tests++;
    if (exp_q.size() != 0 || lat != 3) begin
      n_fail++;
      $display("FAIL sdr_single_latency: first beat cycle=%0d left=%0d, expected cycle 3 left 0", lat, exp_q.size());
    end
    tick();
    n_tests++;
    if (b_uf !== 1'b1 || b_oe !== 1'b0) begin
      n_fail++;
      $display("FAIL sdr_single_underflow: uf=%b oe=%b, expected uf=1 oe=0", b_uf, b_oe);
    end
  endtask

  task automatic test_back_to_back();
    beat_t e;
    logic [3:0] words [0:2];
    int idx = 0;
    bit started = 0;
    bit acc;
    words[0] = 4'h1; words[1] = 4'h2; words[2] = 4'h3;
    exp_q.delete();
    c_en = 1; c_d = words[0]; c_v = 1;
    for (int cyc = 0; cyc < 60 && (idx < 3 || exp_q.size() > 0); cyc++) begin
      acc = c_v && c_rdy;
      tick();
      if (acc) begin
        push_word({12'h000, c_d}, 2, 1'b1);
        idx++;
        if (idx < 3) c_d = words[idx];
        else c_v = 0;
      end
      if (c_oe) begin
        started = 1;
        e = exp_q.pop_front();
        n_tests++;
        if (c_q !== e.q || c_ws !== e.ws || c_uf !== 1'b0) begin
          n_fail++;
          $display("FAIL stream_beat: q=%b ws=%b uf=%b, expected q=%b ws=%b uf=0", c_q, c_ws, c_uf, e.q, e.ws);
        end
      end else if (started && exp_q.size() > 0) begin
        n_tests++; n_fail++;
        $display("FAIL stream_gap: oe=0 with %0d beats pending, expected 1", exp_q.size());
      end
    end
    n_tests++;
    if (idx != 3 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL stream_timeout: accepted=%0d left=%0d, expected 3 and 0", idx, exp_q.size());
    end
    tick();
    n_tests++;
    if (c_uf !== 1'b1) begin n_fail++; $display("FAIL stream_underflow: uf=%b, expected 1", c_uf); end
  endtask

  task automatic test_enable();
    beat_t e;
    int lat = -1;
    int pops = 0;
    bit oe_seen = 0;
    exp_q.delete();
    a_en = 0; a_d = 8'hFF; a_v = 1;
    tick();
    a_d = 8'h00;
    n_tests++;
    if (a_rdy !== 1'b0) begin n_fail++; $display("FAIL en_hold_ready: rdy=%b, expected 0", a_rdy); end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (a_oe) oe_seen = 1;
    end
    n_tests++;
    if (oe_seen || a_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL en_disabled_idle: oe_seen=%b rdy=%b, expected 0 0", oe_seen, a_rdy);
    end
    a_v = 0; a_en = 1;
    push_word(16'h00FF, 4, 1'b1);
    for (int cyc = 1; cyc <= 30 && exp_q.size() > 0; cyc++) begin
      tick();
      if (a_oe) begin
        if (lat < 0) lat = cyc;
        e = exp_q.pop_front();
        pops++;
        if (pops == 2) a_en = 0;
        n_tests++;
        if (a_q !== e.q || a_ws !== e.ws || a_uf !== 1'b0) begin
          n_fail++;
          $display("FAIL en_beat: q=%b ws=%b uf=%b, expected q=%b ws=%b uf=0", a_q, a_ws, a_uf, e.q, e.ws);
        end
      end
    end
    n_tests++;
    if (exp_q.size() != 0 || lat != 2) begin
      n_fail++;
      $display("FAIL en_latency: first beat cycle=%0d left=%0d, expected cycle 2 left 0", lat, exp_q.size());
    end
    tick();
    n_tests++;
    if (a_uf !== 1'b0 || a_oe !== 1'b0 || a_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL en_drop_no_underflow: uf=%b oe=%b rdy=%b, expected 0 0 1", a_uf, a_oe, a_rdy);
    end
    a_en = 1;
    tick();
  endtask

  task automatic test_reset_mid_word();
    beat_t e;
    int pops = 0;
    int lat = -1;
    exp_q.delete();
    a_en = 1; a_d = 8'hA5; a_v = 1;
    push_word(16'h00A5, 4, 1'b1);
    for (int cyc = 1; cyc <= 30 && pops < 3; cyc++) begin
      tick();
      a_v = 0;
      if (a_oe) begin
        e = exp_q.pop_front();
        pops++;
      end
    end
    n_tests++;
    if (pops != 3 || a_q !== 2'b10) begin
      n_fail++;
      $display("FAIL rst_mid_beat2: pops=%0d q=%b, expected 3 and 10", pops, a_q);
    end
    rst_n = 0;
    #1;
    n_tests++;
    if (a_q !== 2'b00 || a_oe !== 1'b0 || a_rdy !== 1'b0 || a_ws !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_async: q=%b oe=%b rdy=%b ws=%b, expected 00 0 0 0", a_q, a_oe, a_rdy, a_ws);
    end
    tick();
    rst_n = 1;
    tick();
    n_tests++;
    if (a_rdy !== 1'b1 || a_oe !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_release: rdy=%b oe=%b, expected 1 0", a_rdy, a_oe);
    end
    exp_q.delete();
    a_d = 8'h5A; a_v = 1;
    push_word(16'h005A, 4, 1'b1);
    for (int cyc = 1; cyc <= 30 && exp_q.size() > 0; cyc++) begin
      tick();
      a_v = 0;
      if (a_oe) begin
        if (lat < 0) lat = cyc;
        e = exp_q.pop_front();
        n_tests++;
        if (a_q !== e.q || a_ws !== e.ws) begin
          n_fail++;
          $display("FAIL rst_mid_next_beat: q=%b ws=%b, expected q=%b ws=%b", a_q, a_ws, e.q, e.ws);
        end
      end
    end
    n_tests++;
    if (exp_q.size() != 0 || lat != 3) begin
      n_fail++;
      $display("FAIL rst_mid_next_latency: cycle=%0d left=%0d, expected 3 and 0", lat, exp_q.size());
    end
    tick();
    tick();
  endtask

  task automatic test_backpressure();
    beat_t e;
    int n_acc = 0;
    bit started = 0;
    bit acc;
    exp_q.delete();
    a_en = 1; a_v = 1; a_d = 8'($urandom);
    for (int cyc = 0; cyc < 200 && (n_acc < 5 || exp_q.size() > 0); cyc++) begin
      acc = a_v && a_rdy;
      tick();
      if (acc) begin
        push_word({8'h00, a_d}, 4, 1'b1);
        n_acc++;
        if (n_acc == 5) a_v = 0;
      end
      a_d = 8'($urandom);
      if (a_oe) begin
        started = 1;
        e = exp_q.pop_front();
        n_tests++;
        if (a_q !== e.q || a_ws !== e.ws || a_uf !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_beat: q=%b ws=%b uf=%b, expected q=%b ws=%b uf=0", a_q, a_ws, a_uf, e.q, e.ws);
        end
      end else if (started && exp_q.size() > 0) begin
        n_tests++; n_fail++;
        $display("FAIL bp_gap: oe=0 with %0d beats pending, expected 1", exp_q.size());
      end
    end
    n_tests++;
    if (n_acc != 5 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL bp_timeout: accepted=%0d left=%0d, expected 5 and 0", n_acc, exp_q.size());
    end
    tick();
    n_tests++;
    if (a_uf !== 1'b1) begin n_fail++; $display("FAIL bp_underflow: uf=%b, expected 1", a_uf); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_ddr_single();
    test_sdr_single();
    test_back_to_back();
    test_enable();
    test_reset_mid_word();
    test_backpressure();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
